ir_transmitter: RTL and testbench

- NEC-format infrared transmitter; the counterpart of the IR receiver.
- Serialises a 32-bit word into a frame: guidance burst, 32 pulse-distance bits sent LSB first, stop burst, trailing gap.
- Drives two outputs: a demodulated-level line (idle high, mark = low) that loops directly into the receiver's iIRDA, and a 38 kHz modulated LED drive.
- Sits beside the receiver on the 50 MHz clock domain.

---
 rtl/ir_transmitter.sv | 173 +++++++++++++++++
 tb/tb_ir_transmitter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ir_transmitter.sv
// NEC-format IR transmitter: guidance burst, 32 pulse-distance bits LSB
// first, stop burst and trailing gap.
//
// Ports:
//   iCLK     in   1  clock (50 MHz)
//   iRST_n   in   1  asynchronous active-low reset
//   iSTART   in   1  frame request, sampled only in IDLE
//   iDATA    in  32  word to send, iDATA[0] goes out first
//   oBUSY    out  1  high while a frame (including the gap) is in progress
//   oDONE    out  1  one-cycle pulse in the first IDLE cycle after a frame
//   oIRDA    out  1  demodulated level, 1 = space/idle, 0 = mark
//   oIR_MOD  out  1  carrier-gated LED drive, carrier only during marks
module ir_transmitter #(
    parameter int LEAD_MARK_DUR  = 450000,
    parameter int LEAD_SPACE_DUR = 225000,
    parameter int BIT_MARK_DUR   = 28000,
    parameter int ZERO_SPACE_DUR = 28000,
    parameter int ONE_SPACE_DUR  = 84500,
    parameter int GAP_DUR        = 500000,
    parameter int CARRIER_HALF   = 658
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iSTART,
    input  logic [31:0] iDATA,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oIRDA,
    output logic        oIR_MOD
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_GAP
    } state_t;

    // Terminal counts: a state lasting N cycles ends when the counter is N-1.
    localparam logic [18:0] C_LM   = 19'(LEAD_MARK_DUR - 1);
    localparam logic [18:0] C_LS   = 19'(LEAD_SPACE_DUR - 1);
    localparam logic [18:0] C_BM   = 19'(BIT_MARK_DUR - 1);
    localparam logic [18:0] C_ZS   = 19'(ZERO_SPACE_DUR - 1);
    localparam logic [18:0] C_OS   = 19'(ONE_SPACE_DUR - 1);
    localparam logic [18:0] C_GAP  = 19'(GAP_DUR - 1);
    localparam logic [9:0]  C_HALF = 10'(CARRIER_HALF - 1);

    state_t      r_state;
    logic [18:0] r_cnt;
    logic [31:0] r_shift;
    logic [4:0]  r_bit;
    logic [9:0]  r_car;
    logic        r_tog;
    logic        r_busy;
    logic        r_done;
    logic        r_irda;
    logic        r_mod;

    state_t      w_nxt;
    logic        w_end;
    logic        w_accept;
    logic        w_mark_cur;
    logic        w_mark_nxt;
    logic [9:0]  w_car_nxt;
    logic        w_tog_nxt;

    always_comb begin
        w_nxt = r_state;
        w_end = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (iSTART) w_nxt = S_LEAD_MARK;
            end
            S_LEAD_MARK: begin
                w_end = (r_cnt == C_LM);
                if (w_end) w_nxt = S_LEAD_SPACE;
            end
            S_LEAD_SPACE: begin
                w_end = (r_cnt == C_LS);
                if (w_end) w_nxt = S_BIT_MARK;
            end
            S_BIT_MARK: begin
                w_end = (r_cnt == C_BM);
                if (w_end) w_nxt = S_BIT_SPACE;
            end
            S_BIT_SPACE: begin
                // Space length encodes the bit currently at the LSB.
                w_end = (r_cnt == (r_shift[0] ? C_OS : C_ZS));
                if (w_end)
                    w_nxt = (r_bit == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            end
            S_STOP_MARK: begin
                w_end = (r_cnt == C_BM);
                if (w_end) w_nxt = S_GAP;
            end
            S_GAP: begin
                w_end = (r_cnt == C_GAP);
                if (w_end) w_nxt = S_IDLE;
            end
            default: begin
                w_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept   = (r_state == S_IDLE) && iSTART;
    assign w_mark_cur = (r_state == S_LEAD_MARK) ||
                        (r_state == S_BIT_MARK)  ||
                        (r_state == S_STOP_MARK);
    assign w_mark_nxt = (w_nxt == S_LEAD_MARK) ||
                        (w_nxt == S_BIT_MARK)  ||
                        (w_nxt == S_STOP_MARK);

    // Carrier restarts with the phase high on every mark entry and is
    // held cleared outside marks.
    always_comb begin
        w_car_nxt = 10'd0;
        w_tog_nxt = 1'b0;
        if (w_mark_nxt && !w_mark_cur) begin
            w_tog_nxt = 1'b1;
        end else if (w_mark_nxt) begin
            if (r_car == C_HALF) begin
                w_tog_nxt = ~r_tog;
            end else begin
                w_car_nxt = r_car + 10'd1;
                w_tog_nxt = r_tog;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 19'd0;
            r_shift <= 32'd0;
            r_bit   <= 5'd0;
            r_car   <= 10'd0;
            r_tog   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_irda  <= 1'b1;
            r_mod   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if ((w_nxt != r_state) || (r_state == S_IDLE))
                r_cnt <= 19'd0;
            else
                r_cnt <= r_cnt + 19'd1;
            if (w_accept) begin
                r_shift <= iDATA;
                r_bit   <= 5'd0;
            end else if ((r_state == S_BIT_SPACE) && w_end) begin
                r_shift <= {1'b0, r_shift[31:1]};
                r_bit   <= r_bit + 5'd1;
            end
            r_car  <= w_car_nxt;
            r_tog  <= w_tog_nxt;
            r_busy <= (w_nxt != S_IDLE);
            r_done <= (r_state == S_GAP) && w_end;
            r_irda <= ~w_mark_nxt;
            r_mod  <= w_mark_nxt & w_tog_nxt;
        end
    end

    assign oBUSY   = r_busy;
    assign oDONE   = r_done;
    assign oIRDA   = r_irda;
    assign oIR_MOD = r_mod;

endmodule

// File: tb/tb_ir_transmitter.sv
// Self-checking bench for ir_transmitter with shortened timing parameters.
// Expected waveforms come from a segment-list model of the NEC frame.
module tb_ir_transmitter;

    localparam int LM   = 40;
    localparam int LS   = 20;
    localparam int BM   = 6;
    localparam int ZS   = 6;
    localparam int OS   = 15;
    localparam int GAP  = 25;
    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] data = 32'd0;
    logic        busy;
    logic        done;
    logic        irda;
    logic        irmod;

    int n_assert = 0;
    int n_fail   = 0;
    int fno      = 0;

    logic [1:0] exp_q[$];
    logic       obs_q[$];

    ir_transmitter #(
        .LEAD_MARK_DUR (LM),
        .LEAD_SPACE_DUR(LS),
        .BIT_MARK_DUR  (BM),
        .ZERO_SPACE_DUR(ZS),
        .ONE_SPACE_DUR (OS),
        .GAP_DUR       (GAP),
        .CARRIER_HALF  (HALF)
    ) dut (
        .iCLK   (clk),
        .iRST_n (rst_n),
        .iSTART (start),
        .iDATA  (data),
        .oBUSY  (busy),
        .oDONE  (done),
        .oIRDA  (irda),
        .oIR_MOD(irmod)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One segment of constant level; marks carry a carrier that is high
    // for the first HALF cycles, low for the next HALF, and so on.
    task automatic add_seg(input logic lvl, input int len);
        for (int k = 0; k < len; k++) begin
            if (lvl)
                exp_q.push_back(2'b10);
            else
                exp_q.push_back({1'b0, ((k / HALF) % 2) == 0});
        end
    endtask

    task automatic build(input logic [31:0] d);
        exp_q.delete();
        add_seg(1'b0, LM);
        add_seg(1'b1, LS);
        for (int b = 0; b < 32; b++) begin
            add_seg(1'b0, BM);
            add_seg(1'b1, d[b] ? OS : ZS);
        end
        add_seg(1'b0, BM);
        add_seg(1'b1, GAP);
    endtask

    // Pulse-distance decode of the captured demodulated line.
    task automatic decode_check(input logic [31:0] d);
        int runs[$];
        int len;
        logic lvl;
        logic [31:0] w;
        len = 0;
        lvl = obs_q[0];
        foreach (obs_q[j]) begin
            if (obs_q[j] == lvl) begin
                len++;
            end else begin
                runs.push_back(len);
                lvl = obs_q[j];
                len = 1;
            end
        end
        runs.push_back(len);
        w = 32'd0;
        for (int b = 0; b < 32; b++) begin
            if (3 + 2 * b < runs.size())
                w[b] = (runs[3 + 2 * b] > (ZS + OS) / 2);
        end
        chk($sformatf("frame%0d loopback", fno), w, d);
        chk($sformatf("frame%0d lead_mark_len", fno), 32'(runs[0]), 32'(LM));
        chk($sformatf("frame%0d lead_space_len", fno),
            32'(runs.size() > 1 ? runs[1] : 0), 32'(LS));
        chk($sformatf("frame%0d run_count", fno), 32'(runs.size()), 32'd68);
    endtask

    task automatic request(input logic [31:0] d);
        @(negedge clk);
        start = 1'b1;
        data  = d;
    endtask

    // Walks one frame whose acceptance edge has just been requested.
    task automatic play(input logic [31:0] d, input int poke_at,
                        input int abort_at, input bit chain,
                        input logic [31:0] d2);
        int n;
        fno++;
        build(d);
        obs_q.delete();
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("frame%0d cyc%0d", fno, i),
                {28'd0, busy, done, irda, irmod},
                {28'd0, 1'b1, 1'b0, exp_q[i]});
            obs_q.push_back(irda);
            if (i == 0) begin
                start = 1'b0;
                data  = $urandom;
            end
            if (i == poke_at) begin
                start = 1'b1;
                data  = 32'h1111_1111;
            end
            if (i == poke_at + 1) start = 1'b0;
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk($sformatf("frame%0d abort", fno),
                    {28'd0, busy, done, irda, irmod}, 32'h2);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                for (int j = 0; j < 50; j++) begin
                    @(negedge clk);
                    chk($sformatf("frame%0d post_abort%0d", fno, j),
                        {28'd0, busy, done, irda, irmod}, 32'h2);
                end
                return;
            end
        end
        @(negedge clk);
        chk($sformatf("frame%0d done", fno),
            {28'd0, busy, done, irda, irmod}, 32'h6);
        decode_check(d);
        if (chain) begin
            start = 1'b1;
            data  = d2;
        end else begin
            start = 1'b0;
            @(negedge clk);
            chk($sformatf("frame%0d post_idle", fno),
                {28'd0, busy, done, irda, irmod}, 32'h2);
        end
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        repeat (3) @(negedge clk);
        chk("in_reset", {28'd0, busy, done, irda, irmod}, 32'h2);
        rst_n = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d", i),
                {28'd0, busy, done, irda, irmod}, 32'h2);
        end

        request(32'h0000_0000);
        play(32'h0000_0000, -1, -1, 1'b0, 32'd0);
        request(32'h0000_0001);
        play(32'h0000_0001, -1, -1, 1'b0, 32'd0);
        request(32'h8000_0000);
        play(32'h8000_0000, -1, -1, 1'b0, 32'd0);
        request(32'hE51A_02FD);
        play(32'hE51A_02FD, 300, -1, 1'b0, 32'd0);

        r1 = $urandom;
        r2 = $urandom;
        request(r1);
        play(r1, 150, -1, 1'b1, r2);
        play(r2, -1, -1, 1'b0, 32'd0);

        for (int k = 0; k < 3; k++) begin
            r1 = $urandom;
            request(r1);
            play(r1, -1, -1, 1'b0, 32'd0);
        end

        r1 = $urandom;
        request(r1);
        play(r1, -1, LM + LS + BM + 2, 1'b0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
